axioma_gpio_ext: RTL and testbench

//   Parametrised AVR-style GPIO for AxiomaCore-328 I/O space: NUM_PORTS ports of PORT_WIDTH pins.

---
 rtl/axioma_gpio_ext_pkg.sv | 31 +++
 rtl/axioma_gpio_ext_if.sv | 29 ++
 rtl/axioma_gpio_ext_sync_db.sv | 63 ++++++
 rtl/axioma_gpio_ext.sv | 204 ++++++++++++++++++++
 tb/tb_axioma_gpio_ext.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axioma_gpio_ext_pkg.sv
// Shared definitions for the AxiomaCore GPIO block: default I/O addresses,
// register-select types and the address-range overlap helper.
package axioma_gpio_ext_pkg;

    localparam int IO_PORT_BASE  = 'h23;
    localparam int IO_PCMSK_BASE = 'h6B;
    localparam int IO_PCICR_ADDR = 'h68;
    localparam int IO_PCIFR_ADDR = 'h3B;
    localparam int IO_DBEN_ADDR  = 'h70;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PIN,
        REG_DDR,
        REG_PORT,
        REG_PCMSK,
        REG_PCICR,
        REG_PCIFR,
        REG_DBEN
    } gpio_reg_e;

    typedef struct packed {
        gpio_reg_e  kind;
        logic [2:0] port;
    } gpio_sel_t;

    function automatic bit ranges_overlap(int a_lo, int a_n, int b_lo, int b_n);
        return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

endpackage

// File: rtl/axioma_gpio_ext_if.sv
// CPU I/O-space bus as seen by the GPIO block: address, write data/strobe,
// read enable and combinational read data.
interface axioma_gpio_ext_if #(
    parameter int ADDR_W = 8
) ();

    logic [ADDR_W-1:0] io_addr;
    logic [7:0]        io_data_in;
    logic              io_write;
    logic              io_read;
    logic [7:0]        io_data_out;

    modport master (
        output io_addr,
        output io_data_in,
        output io_write,
        output io_read,
        input  io_data_out
    );

    modport slave (
        input  io_addr,
        input  io_data_in,
        input  io_write,
        input  io_read,
        output io_data_out
    );

endinterface

// File: rtl/axioma_gpio_ext_sync_db.sv
// Per-port input conditioning: 2-flop synchroniser followed by an optional
// 3-sample debounce filter clocked by a shared sample tick.
module axioma_gpio_sync_db #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pin_in_i,
    input  logic         db_en_i,
    input  logic         tick_i,
    output logic [W-1:0] pin_val_o
);

    logic [W-1:0]   s1_q;
    logic [W-1:0]   s2_q;
    logic [W-1:0]   filt_q;
    logic [W-1:0]   filt_d;
    logic [3*W-1:0] sh_q;
    logic [3*W-1:0] sh_d;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pin
            logic [2:0] sh_nxt;
            logic       filt_nxt;

            // While the filter is off, its history shadows the synchroniser so
            // that turning it on never flips the reported level.
            always_comb begin
                sh_nxt   = sh_q[3*gi +: 3];
                filt_nxt = filt_q[gi];
                if (!db_en_i) begin
                    sh_nxt   = {3{s2_q[gi]}};
                    filt_nxt = s2_q[gi];
                end else if (tick_i) begin
                    sh_nxt = {sh_q[3*gi +: 2], s2_q[gi]};
                    if ((&sh_nxt) || (~|sh_nxt)) begin
                        filt_nxt = s2_q[gi];
                    end
                end
            end

            assign sh_d[3*gi +: 3] = sh_nxt;
            assign filt_d[gi]      = filt_nxt;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            filt_q <= '0;
            sh_q   <= '0;
        end else begin
            s1_q   <= pin_in_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            sh_q   <= sh_d;
        end
    end

    assign pin_val_o = db_en_i ? filt_q : s2_q;

endmodule

// File: rtl/axioma_gpio_ext.sv
// AVR-style GPIO for the AxiomaCore-328 I/O space: PIN/DDR/PORT per port,
// debounced inputs, and masked pin-change interrupts (PCMSKn/PCICR/PCIFR).
module axioma_gpio_ext
    import axioma_gpio_ext_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int PORT_WIDTH = 8,
    parameter int ADDR_W     = 8,
    parameter int PORT_BASE  = IO_PORT_BASE,
    parameter int PCMSK_BASE = IO_PCMSK_BASE,
    parameter int PCICR_ADDR = IO_PCICR_ADDR,
    parameter int PCIFR_ADDR = IO_PCIFR_ADDR,
    parameter int DBEN_ADDR  = IO_DBEN_ADDR,
    parameter int DB_DIV     = 1000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    axioma_gpio_ext_if.slave                bus,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pin_in_i,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_out_o,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_oe_o,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_pullup_o,
    output logic [NUM_PORTS-1:0]            pcint_irq_o,
    input  logic [NUM_PORTS-1:0]            pcint_ack_i
);

    localparam int W     = PORT_WIDTH;
    localparam int CNT_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_DIV - 1);

    generate
        if (NUM_PORTS < 1 || NUM_PORTS > 8 || PORT_WIDTH < 1 || PORT_WIDTH > 8 || DB_DIV < 1) begin : g_bad_param
            $error("axioma_gpio_ext: NUM_PORTS/PORT_WIDTH must be 1..8 and DB_DIV >= 1");
        end
        if (ranges_overlap(PORT_BASE, 3*NUM_PORTS, PCMSK_BASE, NUM_PORTS) ||
            ranges_overlap(PORT_BASE, 3*NUM_PORTS, PCICR_ADDR, 1) ||
            ranges_overlap(PORT_BASE, 3*NUM_PORTS, PCIFR_ADDR, 1) ||
            ranges_overlap(PORT_BASE, 3*NUM_PORTS, DBEN_ADDR, 1) ||
            ranges_overlap(PCMSK_BASE, NUM_PORTS, PCICR_ADDR, 1) ||
            ranges_overlap(PCMSK_BASE, NUM_PORTS, PCIFR_ADDR, 1) ||
            ranges_overlap(PCMSK_BASE, NUM_PORTS, DBEN_ADDR, 1) ||
            ranges_overlap(PCICR_ADDR, 1, PCIFR_ADDR, 1) ||
            ranges_overlap(PCICR_ADDR, 1, DBEN_ADDR, 1) ||
            ranges_overlap(PCIFR_ADDR, 1, DBEN_ADDR, 1)) begin : g_addr_overlap
            $error("axioma_gpio_ext: register address ranges overlap");
        end
    endgenerate

    gpio_sel_t              sel;
    logic [CNT_W-1:0]       tick_cnt_q;
    logic [CNT_W-1:0]       tick_cnt_d;
    logic                   tick;
    logic [NUM_PORTS-1:0]   pcicr_q, pcicr_d;
    logic [NUM_PORTS-1:0]   pcifr_q, pcifr_d;
    logic [NUM_PORTS-1:0]   dben_q, dben_d;
    logic [NUM_PORTS-1:0]   pc_event;
    logic [NUM_PORTS*8-1:0] rd_flat;
    logic [W-1:0]           wdata;
    logic [7:0]             rdata;

    assign wdata = bus.io_data_in[W-1:0];

    // Address decode
    always_comb begin
        sel = '{kind: REG_NONE, port: 3'd0};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.io_addr == ADDR_W'(PORT_BASE + 3*p))     sel = '{kind: REG_PIN,   port: 3'(p)};
            if (bus.io_addr == ADDR_W'(PORT_BASE + 3*p + 1)) sel = '{kind: REG_DDR,   port: 3'(p)};
            if (bus.io_addr == ADDR_W'(PORT_BASE + 3*p + 2)) sel = '{kind: REG_PORT,  port: 3'(p)};
            if (bus.io_addr == ADDR_W'(PCMSK_BASE + p))      sel = '{kind: REG_PCMSK, port: 3'(p)};
        end
        if (bus.io_addr == ADDR_W'(PCICR_ADDR)) sel.kind = REG_PCICR;
        if (bus.io_addr == ADDR_W'(PCIFR_ADDR)) sel.kind = REG_PCIFR;
        if (bus.io_addr == ADDR_W'(DBEN_ADDR))  sel.kind = REG_DBEN;
    end

    assign tick       = (tick_cnt_q == CNT_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [W-1:0] ddr_q, ddr_d;
            logic [W-1:0] port_q, port_d;
            logic [W-1:0] pcmsk_q, pcmsk_d;
            logic [W-1:0] prev_q;
            logic [W-1:0] pin_val;
            logic [7:0]   rd_data;
            logic         hit;

            assign hit = (sel.port == 3'(gi));

            axioma_gpio_sync_db #(.W(W)) u_sync_db (
                .clk       (clk),
                .reset_n   (reset_n),
                .pin_in_i  (pin_in_i[gi*W +: W]),
                .db_en_i   (dben_q[gi]),
                .tick_i    (tick),
                .pin_val_o (pin_val)
            );

            // A write to PIN toggles the output latch instead of touching the input.
            always_comb begin
                ddr_d   = ddr_q;
                port_d  = port_q;
                pcmsk_d = pcmsk_q;
                if (bus.io_write && hit) begin
                    case (sel.kind)
                        REG_PIN:   port_d  = port_q ^ wdata;
                        REG_DDR:   ddr_d   = wdata;
                        REG_PORT:  port_d  = wdata;
                        REG_PCMSK: pcmsk_d = wdata;
                        default:   ;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ddr_q   <= '0;
                    port_q  <= '0;
                    pcmsk_q <= '0;
                    prev_q  <= '0;
                end else begin
                    ddr_q   <= ddr_d;
                    port_q  <= port_d;
                    pcmsk_q <= pcmsk_d;
                    prev_q  <= pin_val;
                end
            end

            // Mask is applied to the input change only, so PCMSK writes alone never flag.
            assign pc_event[gi] = |((pin_val ^ prev_q) & pcmsk_q);

            always_comb begin
                rd_data = 8'h00;
                if (hit) begin
                    case (sel.kind)
                        REG_PIN:   rd_data = 8'(pin_val);
                        REG_DDR:   rd_data = 8'(ddr_q);
                        REG_PORT:  rd_data = 8'(port_q);
                        REG_PCMSK: rd_data = 8'(pcmsk_q);
                        default:   rd_data = 8'h00;
                    endcase
                end
            end

            assign rd_flat[gi*8 +: 8]      = rd_data;
            assign pin_out_o[gi*W +: W]    = port_q;
            assign pin_oe_o[gi*W +: W]     = ddr_q;
            assign pin_pullup_o[gi*W +: W] = ~ddr_q & port_q;
        end
    endgenerate

    // Flag clears (W1C, ack) are applied first so a same-cycle event wins.
    always_comb begin
        pcicr_d = pcicr_q;
        dben_d  = dben_q;
        pcifr_d = pcifr_q;
        if (bus.io_write) begin
            case (sel.kind)
                REG_PCICR: pcicr_d = bus.io_data_in[NUM_PORTS-1:0];
                REG_DBEN:  dben_d  = bus.io_data_in[NUM_PORTS-1:0];
                REG_PCIFR: pcifr_d = pcifr_q & ~bus.io_data_in[NUM_PORTS-1:0];
                default:   ;
            endcase
        end
        pcifr_d = (pcifr_d & ~pcint_ack_i) | pc_event;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            pcicr_q    <= '0;
            pcifr_q    <= '0;
            dben_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pcicr_q    <= pcicr_d;
            pcifr_q    <= pcifr_d;
            dben_q     <= dben_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (bus.io_read) begin
            case (sel.kind)
                REG_PCICR: rdata = 8'(pcicr_q);
                REG_PCIFR: rdata = 8'(pcifr_q);
                REG_DBEN:  rdata = 8'(dben_q);
                REG_PIN, REG_DDR, REG_PORT, REG_PCMSK: begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        rdata = rdata | rd_flat[p*8 +: 8];
                    end
                end
                default:   rdata = 8'h00;
            endcase
        end
    end

    assign bus.io_data_out = rdata;
    assign pcint_irq_o     = pcifr_q & pcicr_q;

endmodule

// File: tb/tb_axioma_gpio_ext.sv
// Directed and randomized checks of axioma_gpio_ext against a cycle-level
// reference model built from the register rules and pin-to-flag latencies.
module tb_axioma_gpio_ext;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axioma_gpio_ext_if #(.ADDR_W(8)) bus1 ();
    axioma_gpio_ext_if #(.ADDR_W(8)) bus2 ();

    logic [23:0] pin_in, pin_out, pin_oe, pin_pu;
    logic [2:0]  irq, ack;
    logic [9:0]  pin_in2, pin_out2, pin_oe2, pin_pu2;
    logic [1:0]  irq2, ack2;

    axioma_gpio_ext #(.NUM_PORTS(3), .PORT_WIDTH(8), .DB_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .pin_in_i(pin_in), .pin_out_o(pin_out), .pin_oe_o(pin_oe),
        .pin_pullup_o(pin_pu), .pcint_irq_o(irq), .pcint_ack_i(ack)
    );

    axioma_gpio_ext #(.NUM_PORTS(2), .PORT_WIDTH(5)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .pin_in_i(pin_in2), .pin_out_o(pin_out2), .pin_oe_o(pin_oe2),
        .pin_pullup_o(pin_pu2), .pcint_irq_o(irq2), .pcint_ack_i(ack2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state (main instance, 3 ports x 8 pins)
    logic [23:0] h [4];
    logic [7:0]  m_ddr [3];
    logic [7:0]  m_port [3];
    logic [7:0]  m_pcmsk [3];
    logic [2:0]  m_pcicr, m_pcifr, m_dben;

    logic [7:0] wtab [15] = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B,
                              8'h6B, 8'h6C, 8'h6D, 8'h68, 8'h3B, 8'h3B};
    logic [7:0] rtab [20] = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B,
                              8'h6B, 8'h6C, 8'h6D, 8'h68, 8'h3B, 8'h70,
                              8'h2C, 8'h6E, 8'h00, 8'h22, 8'hFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        bus1.io_addr = a; bus1.io_data_in = d; bus1.io_write = 1'b1;
        @(negedge clk);
        bus1.io_write = 1'b0;
    endtask

    task automatic rd1(input logic [7:0] a, output logic [7:0] d);
        bus1.io_addr = a; bus1.io_read = 1'b1;
        #1 d = bus1.io_data_out;
        bus1.io_read = 1'b0;
    endtask

    task automatic wr2(input logic [7:0] a, input logic [7:0] d);
        bus2.io_addr = a; bus2.io_data_in = d; bus2.io_write = 1'b1;
        @(negedge clk);
        bus2.io_write = 1'b0;
    endtask

    task automatic rd2(input logic [7:0] a, output logic [7:0] d);
        bus2.io_addr = a; bus2.io_read = 1'b1;
        #1 d = bus2.io_data_out;
        bus2.io_read = 1'b0;
    endtask

    function automatic logic [7:0] mread(input logic [7:0] a);
        int ai, p, r;
        ai = int'(a);
        if (ai >= 'h23 && ai <= 'h2B) begin
            p = (ai - 'h23) / 3;
            r = (ai - 'h23) % 3;
            if (r == 0) return h[1][p*8 +: 8];
            if (r == 1) return m_ddr[p];
            return m_port[p];
        end
        if (ai >= 'h6B && ai <= 'h6D) return m_pcmsk[ai - 'h6B];
        if (ai == 'h68) return {5'b0, m_pcicr};
        if (ai == 'h3B) return {5'b0, m_pcifr};
        if (ai == 'h70) return {5'b0, m_dben};
        return 8'h00;
    endfunction

    // h[0] is the newest pin sample; PIN shows the sample one edge older,
    // and a flag is raised when that visible value changed on the last edge.
    task automatic model_edge(input logic [23:0] pin, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic [2:0] k);
        logic [2:0] ev, clr;
        int ai, p, r;
        ev = 3'b0; clr = 3'b0; ai = int'(a);
        for (int i = 0; i < 3; i++) ev[i] = |((h[1][i*8 +: 8] ^ h[2][i*8 +: 8]) & m_pcmsk[i]);
        if (w) begin
            if (ai >= 'h23 && ai <= 'h2B) begin
                p = (ai - 'h23) / 3;
                r = (ai - 'h23) % 3;
                if (r == 0) m_port[p] = m_port[p] ^ d;
                else if (r == 1) m_ddr[p] = d;
                else m_port[p] = d;
            end else if (ai >= 'h6B && ai <= 'h6D) m_pcmsk[ai - 'h6B] = d;
            else if (ai == 'h68) m_pcicr = d[2:0];
            else if (ai == 'h3B) clr = d[2:0];
            else if (ai == 'h70) m_dben = d[2:0];
        end
        m_pcifr = ev | (m_pcifr & ~clr & ~k);
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = pin;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] a;
        logic       w;
        logic       done;
        int         op;

        bus1.io_addr = 8'h00; bus1.io_data_in = 8'h00; bus1.io_write = 1'b0; bus1.io_read = 1'b0;
        bus2.io_addr = 8'h00; bus2.io_data_in = 8'h00; bus2.io_write = 1'b0; bus2.io_read = 1'b0;
        pin_in = 24'hFFFFFF; ack = 3'b0; pin_in2 = 10'h0; ack2 = 2'b0;

        // T1 reset
        repeat (3) @(negedge clk);
        check("rst_pin_out", 32'(pin_out), 32'h0);
        check("rst_pin_oe", 32'(pin_oe), 32'h0);
        check("rst_pullup", 32'(pin_pu), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd1(8'h23, d); check("rst_rdata", 32'(d), 32'h0);
        reset_n = 1'b1;
        @(negedge clk); rd1(8'h23, d); check("t1_pin_1clk", 32'(d), 32'h00);
        @(negedge clk); rd1(8'h23, d); check("t1_pin_2clk", 32'(d), 32'hFF);
        repeat (3) @(negedge clk);
        rd1(8'h3B, d); check("t1_pcifr", 32'(d), 32'h0);

        // T2 direction / pull-ups / PIN toggle
        wr1(8'h24, 8'h0F); wr1(8'h25, 8'hF0);
        check("t2_oe", 32'(pin_oe), 32'h00000F);
        check("t2_out", 32'(pin_out), 32'h0000F0);
        check("t2_pullup", 32'(pin_pu), 32'h0000F0);
        wr1(8'h23, 8'h81);
        rd1(8'h25, d); check("t2_port_toggle", 32'(d), 32'h71);
        check("t2_pullup2", 32'(pin_pu), 32'h000070);
        rd1(8'h23, d); check("t2_pin_unaffected", 32'(d), 32'hFF);

        // T3 pin-change interrupt latency
        wr1(8'h6C, 8'h04); wr1(8'h68, 8'h02);
        pin_in[10] = 1'b0;
        @(negedge clk); rd1(8'h3B, d); check("t3_flag_1clk", 32'(d), 32'h0);
        @(negedge clk); rd1(8'h3B, d); check("t3_flag_2clk", 32'(d), 32'h0);
        rd1(8'h26, d); check("t3_pin1", 32'(d), 32'hFB);
        @(negedge clk); rd1(8'h3B, d); check("t3_flag_3clk", 32'(d), 32'h02);
        check("t3_irq", 32'(irq), 32'h2);
        wr1(8'h3B, 8'h02);
        check("t3_irq_clr", 32'(irq), 32'h0);
        pin_in[11] = 1'b0;
        repeat (5) @(negedge clk);
        rd1(8'h3B, d); check("t3_unmasked", 32'(d), 32'h0);

        // T4 set/clear collision, then ack
        pin_in[10] = 1'b1;
        repeat (2) @(negedge clk);
        wr1(8'h3B, 8'h02);
        rd1(8'h3B, d); check("t4_set_wins", 32'(d), 32'h02);
        ack = 3'b010;
        @(negedge clk); ack = 3'b0;
        rd1(8'h3B, d); check("t4_ack_clear", 32'(d), 32'h0);
        check("t4_irq", 32'(irq), 32'h0);

        // T5 debounce (DB_DIV = 4)
        wr1(8'h6B, 8'h01); wr1(8'h70, 8'h01);
        rd1(8'h70, d); check("t5_dben", 32'(d), 32'h01);
        for (int g = 0; g < 3; g++) begin
            pin_in[0] = 1'b0;
            @(negedge clk); pin_in[0] = 1'b1;
            repeat (5) @(negedge clk);
            rd1(8'h23, d); check("t5_glitch_pin", 32'(d), 32'hFF);
        end
        rd1(8'h3B, d); check("t5_glitch_flag", 32'(d), 32'h0);
        pin_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        rd1(8'h23, d); check("t5_early_pin", 32'(d), 32'hFF);
        done = 1'b0;
        for (int i = 4; i <= 16; i++) begin
            rd1(8'h23, d);
            if (d == 8'hFE) begin done = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_settle_16clk", 32'(done), 32'h1);
        repeat (2) @(negedge clk);
        rd1(8'h3B, d); check("t5_flag", 32'(d), 32'h01);
        wr1(8'h70, 8'h00); wr1(8'h3B, 8'h07);
        @(negedge clk);
        rd1(8'h3B, d); check("t5_off_noflag", 32'(d), 32'h0);

        // T6 narrow instance: 2 ports x 5 pins
        wr2(8'h25, 8'hFF); rd2(8'h25, d); check("t6_port0", 32'(d), 32'h1F);
        wr2(8'h28, 8'hFF); rd2(8'h28, d); check("t6_port1", 32'(d), 32'h1F);
        check("t6_pin_out", 32'(pin_out2), 32'h3FF);
        wr2(8'h2B, 8'hFF); rd2(8'h2B, d); check("t6_port2_addr", 32'(d), 32'h0);
        rd2(8'h29, d); check("t6_pin2_addr", 32'(d), 32'h0);
        rd2(8'h6D, d); check("t6_pcmsk2_addr", 32'(d), 32'h0);
        wr2(8'h68, 8'hFF); rd2(8'h68, d); check("t6_pcicr", 32'(d), 32'h03);
        wr2(8'h3B, 8'hFF); rd2(8'h3B, d); check("t6_pcifr", 32'(d), 32'h0);

        // Randomized phase against the reference model
        reset_n = 1'b0;
        pin_in = 24'($urandom);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) h[i] = 24'h0;
        for (int i = 0; i < 3; i++) begin m_ddr[i] = 8'h0; m_port[i] = 8'h0; m_pcmsk[i] = 8'h0; end
        m_pcicr = 3'b0; m_pcifr = 3'b0; m_dben = 3'b0;
        reset_n = 1'b1;
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 9));
            w = 1'b0; a = 8'h00; d = 8'h00;
            if (op < 4) begin
                w = 1'b1;
                a = wtab[$urandom_range(0, 14)];
                d = 8'($urandom);
                bus1.io_addr = a; bus1.io_data_in = d; bus1.io_write = 1'b1;
            end else begin
                a = rtab[$urandom_range(0, 19)];
                bus1.io_addr = a; bus1.io_read = 1'b1;
                #1 check("rnd_read", 32'(bus1.io_data_out), 32'(mread(a)));
                bus1.io_read = 1'b0;
            end
            check("rnd_pin_out", 32'(pin_out), 32'({m_port[2], m_port[1], m_port[0]}));
            check("rnd_pin_oe", 32'(pin_oe), 32'({m_ddr[2], m_ddr[1], m_ddr[0]}));
            check("rnd_pullup", 32'(pin_pu),
                  32'(~{m_ddr[2], m_ddr[1], m_ddr[0]} & {m_port[2], m_port[1], m_port[0]}));
            check("rnd_irq", 32'(irq), 32'(m_pcifr & m_pcicr));
            pin_in = pin_in ^ 24'($urandom & $urandom & $urandom);
            ack = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b0;
            @(posedge clk);
            model_edge(pin_in, w, a, d, ack);
            @(negedge clk);
            bus1.io_write = 1'b0;
            ack = 3'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
